// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I fields into instruction words and streams
// them to instruction memory at consecutive word addresses.
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_start, i_stop         session open (IDLE only) / early close (RUN only)
//   i_base_addr             first write address of a session
//   i_in_valid, o_in_ready  decoded-field stream handshake
//   i_opcode, i_func        major opcode, {funct7, funct3}
//   i_rs1, i_rs2, i_rd      register indices
//   i_imm                   sign-extended byte-offset immediate
//   o_wr_valid, i_wr_ready  memory write handshake
//   o_wr_addr, o_wr_data    write address and encoded word
//   o_busy, o_full          session active / word limit reached
//   o_illegal, o_count      sticky dropped-opcode flag, legal words this session
module inst_encoder #(
    parameter int XLEN      = 32,
    parameter int ILEN      = 32,
    parameter int DEPTH     = 2,
    parameter int MAX_WORDS = 1024
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_start,
    input  logic                           i_stop,
    input  logic [XLEN-1:0]                i_base_addr,
    input  logic                           i_in_valid,
    output logic                           o_in_ready,
    input  logic [6:0]                     i_opcode,
    input  logic [9:0]                     i_func,
    input  logic [4:0]                     i_rs1,
    input  logic [4:0]                     i_rs2,
    input  logic [4:0]                     i_rd,
    input  logic [XLEN-1:0]                i_imm,
    output logic                           o_wr_valid,
    input  logic                           i_wr_ready,
    output logic [XLEN-1:0]                o_wr_addr,
    output logic [ILEN-1:0]                o_wr_data,
    output logic                           o_busy,
    output logic                           o_full,
    output logic                           o_illegal,
    output logic [$clog2(MAX_WORDS+1)-1:0] o_count
);
    localparam int CW = $clog2(MAX_WORDS+1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          r_state, w_next;
    logic [XLEN-1:0] r_addr_q [DEPTH];
    logic [ILEN-1:0] r_data_q [DEPTH];
    logic [PW-1:0]   r_wp, r_rp;
    logic [PW:0]     r_occ;
    logic [XLEN-1:0] r_next_addr;
    logic [CW-1:0]   r_count;
    logic            r_illegal;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [ILEN-1:0] w_enc;
    logic            w_legal, w_accept, w_push, w_pop, w_last;

    assign w_f3 = i_func[2:0];
    assign w_f7 = i_func[9:3];

    always_comb begin
        w_legal = 1'b1;
        w_enc   = '0;
        case (i_opcode)
            7'b0110011: w_enc = {w_f7, i_rs2, i_rs1, w_f3, i_rd, i_opcode};
            // shift-immediates carry funct7 in the upper immediate field
            7'b0010011: w_enc = (w_f3 == 3'b001 || w_f3 == 3'b101) ?
                                {w_f7, i_imm[4:0], i_rs1, w_f3, i_rd, i_opcode} :
                                {i_imm[11:0], i_rs1, w_f3, i_rd, i_opcode};
            7'b0000011,
            7'b1100111: w_enc = {i_imm[11:0], i_rs1, w_f3, i_rd, i_opcode};
            7'b0100011: w_enc = {i_imm[11:5], i_rs2, i_rs1, w_f3, i_imm[4:0], i_opcode};
            7'b1100011: w_enc = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, w_f3,
                                 i_imm[4:1], i_imm[11], i_opcode};
            7'b0110111,
            7'b0010111: w_enc = {i_imm[31:12], i_rd, i_opcode};
            7'b1101111: w_enc = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
            default:    w_legal = 1'b0;
        endcase
    end

    assign o_busy     = r_state != IDLE;
    assign o_full     = r_count == CW'(MAX_WORDS);
    assign o_illegal  = r_illegal;
    assign o_count    = r_count;
    assign o_in_ready = (r_state == RUN) && (r_occ != (PW+1)'(DEPTH)) && !o_full;
    assign o_wr_valid = r_occ != '0;
    assign o_wr_addr  = o_wr_valid ? r_addr_q[r_rp] : '0;
    assign o_wr_data  = o_wr_valid ? r_data_q[r_rp] : '0;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_push     = w_accept && w_legal;
    assign w_pop      = o_wr_valid && i_wr_ready;
    assign w_last     = w_push && (r_count == CW'(MAX_WORDS-1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? RUN : IDLE;
            RUN:     w_next = (i_stop || w_last) ? DRAIN : RUN;
            DRAIN:   w_next = (r_occ == '0) ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_wp        <= '0;
            r_rp        <= '0;
            r_occ       <= '0;
            r_next_addr <= '0;
            r_count     <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_occ   <= r_occ + (PW+1)'(w_push) - (PW+1)'(w_pop);
            if (w_push)
                r_wp <= r_wp + PW'(1);
            if (w_pop)
                r_rp <= r_rp + PW'(1);
            if (r_state == IDLE && i_start) begin
                r_next_addr <= i_base_addr;
                r_count     <= '0;
                r_illegal   <= 1'b0;
            end else if (w_push) begin
                r_next_addr <= r_next_addr + XLEN'(4);
                r_count     <= r_count + CW'(1);
            end else if (w_accept) begin
                r_illegal   <= 1'b1;
            end
        end
    end

    // buffer storage needs no reset: occupancy gates what is visible
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_addr_q[r_wp] <= r_next_addr;
            r_data_q[r_wp] <= w_enc;
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: table vectors, directed corner sequences and random traffic
// checked against a queue-based reference model of inst_encoder.
module tb_inst_encoder;
    localparam int MAXW = 4;
    localparam int DEP  = 2;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, in_valid, in_ready, wr_valid, wr_ready;
    logic        busy, full, illegal;
    logic [31:0] base_addr, imm, wr_addr, wr_data;
    logic [6:0]  opcode;
    logic [9:0]  func;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  count;

    always #5 clk = ~clk;

    inst_encoder #(.XLEN(32), .ILEN(32), .DEPTH(DEP), .MAX_WORDS(MAXW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
        .i_base_addr(base_addr), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_opcode(opcode), .i_func(func), .i_rs1(rs1), .i_rs2(rs2), .i_rd(rd),
        .i_imm(imm), .o_wr_valid(wr_valid), .i_wr_ready(wr_ready),
        .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_busy(busy), .o_full(full),
        .o_illegal(illegal), .o_count(count)
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; } beat_t;
    typedef struct {
        logic [6:0] op; logic [9:0] f; logic [4:0] a, b, d; logic [31:0] i; logic [31:0] exp;
    } vec_t;

    int          checks = 0, errors = 0;
    beat_t       q[$];
    logic        m_busy = 0, m_open = 0, m_illegal = 0;
    int          m_count = 0;
    logic [31:0] m_addr = 0;
    logic        use_tab = 0;
    logic [31:0] tab_word = 0;
    vec_t        tab[13];
    logic [6:0]  ops[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference encoding from the field-placement rules, using shifts and masks.
    function automatic logic [32:0] ref_enc(input int unsigned op, f, a, b, d, i);
        int unsigned f3, f7, w;
        f3 = f & 7;
        f7 = f >> 3;
        case (op)
            'h33: w = (f7 << 25) | (b << 20) | (a << 15) | (f3 << 12) | (d << 7) | op;
            'h13: w = (f3 == 1 || f3 == 5) ?
                      (f7 << 25) | ((i & 31) << 20) | (a << 15) | (f3 << 12) | (d << 7) | op :
                      ((i & 'hFFF) << 20) | (a << 15) | (f3 << 12) | (d << 7) | op;
            'h03, 'h67: w = ((i & 'hFFF) << 20) | (a << 15) | (f3 << 12) | (d << 7) | op;
            'h23: w = (((i >> 5) & 127) << 25) | (b << 20) | (a << 15) | (f3 << 12) | ((i & 31) << 7) | op;
            'h63: w = (((i >> 12) & 1) << 31) | (((i >> 5) & 63) << 25) | (b << 20) | (a << 15) |
                      (f3 << 12) | (((i >> 1) & 15) << 8) | (((i >> 11) & 1) << 7) | op;
            'h37, 'h17: w = (i & 'hFFFFF000) | (d << 7) | op;
            'h6F: w = (((i >> 20) & 1) << 31) | (((i >> 1) & 1023) << 21) | (((i >> 11) & 1) << 20) |
                      (((i >> 12) & 255) << 12) | (d << 7) | op;
            default: return 33'h0;
        endcase
        return {1'b1, w};
    endfunction

    function automatic logic will_accept();
        return in_valid && m_open && q.size() < DEP && m_count < MAXW;
    endfunction

    // One clock: check outputs against the model mid-cycle, then advance the model.
    task automatic step();
        logic [32:0] e;
        logic        acc, pop, exp_ready;
        int          occ;
        @(negedge clk);
        occ       = q.size();
        exp_ready = m_open && occ < DEP && m_count < MAXW;
        chk("in_ready", in_ready, exp_ready);
        chk("wr_valid", wr_valid, occ != 0);
        if (occ != 0) begin
            chk("wr_addr", wr_addr, q[0].addr);
            chk("wr_data", wr_data, q[0].data);
        end
        chk("busy", busy, m_busy);
        chk("full", full, m_count == MAXW);
        chk("illegal", illegal, m_illegal);
        chk("count", count, m_count);
        acc = in_valid && exp_ready;
        pop = occ != 0 && wr_ready;
        e   = ref_enc(32'(opcode), 32'(func), 32'(rs1), 32'(rs2), 32'(rd), imm);
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_busy = 0; m_open = 0; m_illegal = 0; m_count = 0; m_addr = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_open = 1; m_addr = base_addr; m_count = 0; m_illegal = 0;
                end
            end else if (m_open) begin
                if (acc && e[32]) begin
                    q.push_back('{m_addr, use_tab ? tab_word : e[31:0]});
                    m_addr  = m_addr + 4;
                    m_count = m_count + 1;
                end else if (acc) begin
                    m_illegal = 1;
                end
                if (stop || m_count == MAXW) m_open = 0;
            end else if (occ == 0) begin
                m_busy = 0;
            end
        end
        #1;
    endtask

    task automatic set_fields(input logic [6:0] o, input logic [9:0] f, input logic [4:0] a, b, d,
                              input logic [31:0] i);
        opcode = o; func = f; rs1 = a; rs2 = b; rd = d; imm = i;
    endtask

    task automatic start_session(input logic [31:0] base);
        int n = 0;
        in_valid  = 0;
        start     = 1;
        base_addr = base;
        while (!m_open && n < 50) begin
            step();
            n++;
        end
        start = 0;
        if (!m_open) timeout("start_session");
    endtask

    task automatic send();
        int   n = 0;
        logic done = 0;
        in_valid = 1;
        while (!done && n < 20) begin
            done = will_accept();
            step();
            n++;
        end
        if (!done) timeout("send");
    endtask

    task automatic close_session();
        int n = 0;
        in_valid = 0;
        stop     = 1;
        step();
        stop     = 0;
        wr_ready = 1;
        while ((m_busy || q.size() != 0) && n < 50) begin
            step();
            n++;
        end
        if (m_busy) timeout("drain");
    endtask

    initial begin
        tab[0]  = '{7'h23, 10'h002, 5'd1, 5'd2, 5'd0,  32'hFFFFFFFC, 32'hFE20AE23};
        tab[1]  = '{7'h63, 10'h000, 5'd0, 5'd0, 5'd0,  32'hFFFFFFF8, 32'hFE000CE3};
        tab[2]  = '{7'h6F, 10'h000, 5'd0, 5'd0, 5'd1,  32'h00000800, 32'h001000EF};
        tab[3]  = '{7'h33, 10'h000, 5'd1, 5'd2, 5'd3,  32'h0,        32'h002081B3};
        tab[4]  = '{7'h33, 10'h100, 5'd1, 5'd2, 5'd3,  32'h0,        32'h402081B3};
        tab[5]  = '{7'h13, 10'h105, 5'd6, 5'd0, 5'd5,  32'h3,        32'h40335293};
        tab[6]  = '{7'h37, 10'h000, 5'd0, 5'd0, 5'd7,  32'h12345000, 32'h123453B7};
        tab[7]  = '{7'h03, 10'h002, 5'd9, 5'd0, 5'd8,  32'd16,       32'h0104A403};
        tab[8]  = '{7'h67, 10'h000, 5'd1, 5'd0, 5'd0,  32'h0,        32'h00008067};
        tab[9]  = '{7'h17, 10'h000, 5'd0, 5'd0, 5'd10, 32'hFFFFF000, 32'hFFFFF517};
        tab[10] = '{7'h63, 10'h001, 5'd1, 5'd2, 5'd0,  32'd16,       32'h00209863};
        tab[11] = '{7'h13, 10'h001, 5'd1, 5'd0, 5'd1,  32'h000007FF, 32'h01F09093};
        tab[12] = '{7'h6F, 10'h000, 5'd0, 5'd0, 5'd0,  32'hFFFFFFFF, 32'hFFFFF06F};
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h0F};

        rst_n = 0; start = 0; stop = 0; in_valid = 0; wr_ready = 0; base_addr = 0;
        set_fields(7'h13, 10'h0, 5'd0, 5'd0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        step();
        chk("rst_wr_addr", wr_addr, 32'h0);
        chk("rst_wr_data", wr_data, 32'h0);
        rst_n = 1;
        step();

        // ADDI x1,x0,5 at 0x100
        start_session(32'h100);
        set_fields(7'h13, 10'h000, 5'd0, 5'd0, 5'd1, 32'd5);
        use_tab = 1; tab_word = 32'h00500093;
        send();
        in_valid = 0;
        chk("addi_count", count, 32'd1);
        chk("addi_addr", wr_addr, 32'h100);
        chk("addi_data", wr_data, 32'h00500093);
        close_session();

        // table vectors, streamed back to back with memory always ready
        wr_ready = 1;
        for (int i = 0; i < 13; i++) begin
            if (!m_open) start_session(32'h100);
            set_fields(tab[i].op, tab[i].f, tab[i].a, tab[i].b, tab[i].d, tab[i].i);
            tab_word = tab[i].exp;
            send();
        end
        close_session();
        use_tab = 0;

        // back-pressure: buffer fills, output held, then drains in order
        start_session(32'h200);
        wr_ready = 0;
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            set_fields(7'h33, 10'h0, 5'd1, 5'd2, 5'(i + 1), 32'h0);
            step();
        end
        chk("stall_ready", in_ready, 32'd0);
        chk("stall_addr", wr_addr, 32'h200);
        chk("stall_data", wr_data, 32'h002080B3);
        wr_ready = 1;
        for (int i = 0; i < 5; i++) begin
            set_fields(7'h33, 10'h0, 5'd1, 5'd2, 5'(i + 10), 32'h0);
            step();
        end
        close_session();

        // unsupported opcode mid-stream
        start_session(32'h300);
        set_fields(7'h13, 10'h0, 5'd0, 5'd0, 5'd1, 32'd1);
        send();
        set_fields(7'h7F, 10'h0, 5'd0, 5'd0, 5'd2, 32'd2);
        send();
        chk("illegal_set", illegal, 32'd1);
        chk("illegal_count", count, 32'd1);
        set_fields(7'h13, 10'h0, 5'd0, 5'd0, 5'd3, 32'd3);
        send();
        in_valid = 0;
        chk("illegal_count2", count, 32'd2);
        close_session();

        // word limit: offer 6 beats, only 4 legal words fit
        start_session(32'h400);
        wr_ready = 1;
        in_valid = 1;
        for (int i = 0; i < 6; i++) begin
            set_fields(i == 1 ? 7'h7F : 7'h13, 10'h0, 5'd0, 5'd0, 5'(i + 1), 32'(i));
            step();
        end
        in_valid = 0;
        for (int i = 0; i < 6; i++) step();
        chk("max_full", full, 32'd1);
        chk("max_busy", busy, 32'd0);
        chk("max_count", count, 32'd4);
        chk("max_illegal", illegal, 32'd1);
        start_session(32'h500);
        chk("restart_full", full, 32'd0);
        chk("restart_count", count, 32'd0);
        chk("restart_illegal", illegal, 32'd0);
        close_session();

        // reset with two buffered words
        start_session(32'h600);
        wr_ready = 0;
        in_valid = 1;
        set_fields(7'h37, 10'h0, 5'd0, 5'd0, 5'd4, 32'hABCDE000);
        step();
        step();
        in_valid = 0;
        step();
        chk("pre_rst_valid", wr_valid, 32'd1);
        chk("pre_rst_count", count, 32'd2);
        rst_n = 0;
        step();
        rst_n = 1;
        wr_ready = 1;
        chk("rst_valid", wr_valid, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_count", count, 32'd0);
        chk("rst_addr", wr_addr, 32'h0);
        for (int i = 0; i < 5; i++) step();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 15) == 0);
            base_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFFFFFC);
            in_valid  = ($urandom_range(0, 9) < 6);
            wr_ready  = ($urandom_range(0, 9) < 7);
            set_fields(ops[$urandom_range(0, 10)], 10'($urandom), 5'($urandom), 5'($urandom),
                       5'($urandom), $urandom);
            step();
        end
        rst_n = 1;
        start = 0;
        close_session();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

Inverse of the fetch-stage decoder: accepts decoded instruction fields (opcode, func, rs1, rs2, rd, immediate) over a valid/ready stream, packs them into RV32I instruction words, and writes them into instruction memory at consecutive word addresses. Used by the program loader and self-test sequencer to build instruction images in memory, with a small output buffer that absorbs memory back-pressure.

## Interface
- XLEN, 32, address/immediate width
- ILEN, 32, instruction word width
- DEPTH, 2, output buffer entries (power of two, ≥2)
- MAX_WORDS, 1024, maximum legal words per session
- clk  input  1  clock
- rst_n  input  1  synchronous reset, active low
- start  input  1  pulse; opens a session at base_addr (honoured only in IDLE)
- stop  input  1  pulse; ends the session early (honoured only in RUN)
- base_addr  input  XLEN  first write address, word aligned
- in_valid / in_ready  input / output  1  field stream handshake
- opcode  input  7  RV32I major opcode
- func  input  10  {funct7, funct3}, same packing as the decoder
- rs1, rs2, rd  input  5 each  register indices
- imm  input  XLEN  immediate in decoded (sign-extended, byte-offset) form
- wr_valid / wr_ready  output / input  1  memory write handshake
- wr_addr  output  XLEN  write address
- wr_data  output  ILEN  encoded instruction
- busy  output  1  state != IDLE
- full  output  1  count == MAX_WORDS
- illegal  output  1  sticky: an unsupported opcode was dropped this session
- count  output  $clog2(MAX_WORDS+1)  legal words accepted this session

## Operation
- FSM: IDLE → RUN on start (load next_addr=base_addr; clear count, illegal). RUN → DRAIN on stop, or when an accepted legal word makes count == MAX_WORDS. DRAIN → IDLE when buffer empty and no beat pending. start outside IDLE and stop outside RUN are ignored.
- in_ready = (state==RUN) && buffer not full && !full.
- Accepted legal word: {next_addr, encoded} pushed to buffer; next_addr += 4; count += 1.
- Accepted unsupported opcode: handshake completes, word dropped, illegal set, no address or count consumed.
- Encoding (funct3 = func[2:0], funct7 = func[9:3]):
  - OP 0110011: funct7, rs2, rs1, funct3, rd.
  - OP_IMM 0010011: imm[11:0], rs1, funct3, rd; if funct3 is 001 or 101, [31:25]=funct7, [24:20]=imm[4:0].
  - LOAD 0000011, JALR 1100111: imm[11:0], rs1, funct3, rd.
  - STORE 0100011: imm[11:5], rs2, rs1, funct3, imm[4:0] at [11:7].
  - BRANCH 1100011: imm[12]→31, imm[10:5]→30:25, rs2, rs1, funct3, imm[4:1]→11:8, imm[11]→7.
  - LUI 0110111, AUIPC 0010111: imm[31:12]→31:12, rd.
  - JAL 1101111: imm[20]→31, imm[10:1]→30:21, imm[11]→20, imm[19:12]→19:12, rd.
  - imm[0] ignored for BRANCH/JAL; upper imm bits beyond the field are not checked.
- Address arithmetic modulo 2^XLEN (wraps silently).

## Timing
- Reset: state IDLE, buffer empty, in_ready=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, full=0, illegal=0, count=0. Reset mid-session discards buffered words; no write is issued after rst_n is sampled low.
- Latency: beat accepted at edge N → wr_valid high after edge N (earliest), in order.
- wr_valid, wr_addr, wr_data held stable until wr_valid && wr_ready; beat retires on that edge.
- Push and pop in the same cycle with buffer full: not allowed (in_ready already low); with buffer at DEPTH-1 entries, both occur and occupancy is unchanged.
- stop together with an accepted beat: beat is kept, then DRAIN.
- count, full, illegal update on the accepting edge; busy drops the cycle after the last write retires.
- Throughput: one word per cycle with wr_ready held high.

## Test plan
- start, base_addr=0x100; ADDI x1,x0,5 (OP_IMM, func=0, imm=5, rd=1) → wr_addr=0x100, wr_data=0x00500093, count=1.
- SW x2,-4(x1), BRANCH BEQ imm=-8, JAL rd=1 imm=0x800 back to back, wr_ready=1 → 0xFE20AE23, 0xFE000CE3 (rs1=rs2=0), 0x001000EF at 0x100/0x104/0x108, one per cycle.
- wr_ready=0 for 5 cycles while streaming → in_ready falls after DEPTH words buffered, wr_data stable, no loss or reorder after release.
- opcode 0x7F mid-stream → illegal=1, next legal word gets the next consecutive address, count unchanged for the dropped beat.
- MAX_WORDS=4: stream 6 words → in_ready low after 4th, full=1, state drains to IDLE, busy=0; a new start clears full/illegal/count.
- rst_n low with 2 buffered words → wr_valid=0 next cycle, all outputs at reset values, no further writes.
